// File: rtl/pulse_receiver.sv
// rtl/pulse_receiver.sv - serial-to-parallel frame capture with popcount and abort detection
module pulse_receiver #(
  parameter int WIDTH = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             frame_start,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] ones_count,
  output logic             busy,
  output logic             frame_error
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_word;

  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] base, input logic b);
    if (MSB_FIRST) return {base[WIDTH-2:0], b};
    else           return {b, base[WIDTH-1:1]};
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(w[i]);
    return n;
  endfunction

  assign shifted    = insert_bit(shift_q, serial_in);
  assign first_word = insert_bit({WIDTH{1'b0}}, serial_in);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    ones_d    = ones_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    if (clear_err) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && frame_start) begin
          shift_d   = first_word;
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (enable) begin
          if (frame_start) begin
            // Early frame_start wins even on the last bit: restart with this bit as bit 1.
            shift_d   = first_word;
            bit_cnt_d = CNT_W'(1);
            err_d     = 1'b1;
          end else if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            shift_d   = shifted;
            data_d    = shifted;
            ones_d    = popcount(shifted);
            valid_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      ones_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      ones_q    <= ones_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign ones_count  = ones_q;
  assign busy        = (state_q == SHIFT);
  assign frame_error = err_q;

endmodule

// File: tb/tb_pulse_receiver.sv
// tb/tb_pulse_receiver.sv - directed bench for pulse_receiver in MSB-first and LSB-first builds
module tb_pulse_receiver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        serial_in = 1'b0;
  logic        frame_start = 1'b0;
  logic        clear_err = 1'b0;

  logic [15:0] m_data, l_data;
  logic        m_valid, l_valid;
  logic [4:0]  m_ones, l_ones;
  logic        m_busy, l_busy;
  logic        m_err, l_err;

  int total = 0;
  int bad = 0;

  pulse_receiver #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset_n(reset_n), .enable(enable), .serial_in(serial_in),
    .frame_start(frame_start), .clear_err(clear_err), .data_out(m_data),
    .data_valid(m_valid), .ones_count(m_ones), .busy(m_busy), .frame_error(m_err)
  );

  pulse_receiver #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset_n(reset_n), .enable(enable), .serial_in(serial_in),
    .frame_start(frame_start), .clear_err(clear_err), .data_out(l_data),
    .data_valid(l_valid), .ones_count(l_ones), .busy(l_busy), .frame_error(l_err)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic fs, input logic b, input logic en);
    frame_start = fs;
    serial_in   = b;
    enable      = en;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'($urandom), 1'($urandom), 1'b1);
    total++;
    if (m_data !== 16'h0 || m_valid !== 1'b0 || m_ones !== 5'd0 || m_busy !== 1'b0 || m_err !== 1'b0)
      begin bad++; $display("FAIL reset_state: data=%h valid=%b ones=%0d busy=%b err=%b required all 0", m_data, m_valid, m_ones, m_busy, m_err); end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'($urandom), 1'b1);
      total++;
      if (m_busy !== 1'b0 || m_valid !== 1'b0)
        begin bad++; $display("FAIL idle_no_activity: busy=%b valid=%b required 0 0", m_busy, m_valid); end
    end
  endtask

  task automatic test_single();
    logic [15:0] w;
    int vcnt, vpos;
    w = 16'h5254; vcnt = 0; vpos = -1;
    for (int i = 0; i < 16; i++) begin
      drive(i == 0, w[15-i], 1'b1);
      if (m_valid) begin vcnt++; vpos = i; end
    end
    total++;
    if (vcnt !== 1 || vpos !== 15)
      begin bad++; $display("FAIL single_latency: strobes=%0d at tick %0d required 1 at tick 15", vcnt, vpos); end
    total++;
    if (m_data !== 16'h5254) begin bad++; $display("FAIL single_data: got %h required 5254", m_data); end
    total++;
    if (m_ones !== 5'd6) begin bad++; $display("FAIL single_ones: got %0d required 6", m_ones); end
    total++;
    if (m_err !== 1'b0 || m_busy !== 1'b0) begin bad++; $display("FAIL single_flags: err=%b busy=%b required 0 0", m_err, m_busy); end
    drive(1'b0, 1'b0, 1'b0);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL single_strobe_width: valid=%b required 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1, w2, d1, d2;
    logic [4:0]  o2;
    int vcnt, t1, t2;
    logic b;
    w1 = 16'h5254; w2 = 16'hFFFF; vcnt = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0; o2 = '0;
    for (int t = 0; t < 32; t++) begin
      b = (t < 16) ? w1[15-t] : w2[31-t];
      drive((t % 16) == 0, b, 1'b1);
      if (m_valid) begin
        vcnt++;
        if (vcnt == 1) begin t1 = t; d1 = m_data; end
        else begin t2 = t; d2 = m_data; o2 = m_ones; end
      end
    end
    total++;
    if (vcnt !== 2 || t1 !== 15 || t2 !== 31)
      begin bad++; $display("FAIL b2b_timing: strobes=%0d at %0d,%0d required 2 at 15,31", vcnt, t1, t2); end
    total++;
    if (d1 !== 16'h5254) begin bad++; $display("FAIL b2b_first_data: got %h required 5254", d1); end
    total++;
    if (d2 !== 16'hFFFF || o2 !== 5'd16)
      begin bad++; $display("FAIL b2b_second: data=%h ones=%0d required ffff 16", d2, o2); end
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    logic [15:0] w;
    int vcnt, vpos;
    bit busy_ok;
    w = 16'hA5A5; vcnt = 0; vpos = -1; busy_ok = 1;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, w[15-i], 1'b1);
      if (m_busy !== 1'b1) busy_ok = 0;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'b0);
      total++;
      if (m_busy !== 1'b1 || m_valid !== 1'b0)
        begin bad++; $display("FAIL stall_hold: busy=%b valid=%b required 1 0", m_busy, m_valid); end
    end
    for (int i = 8; i < 16; i++) begin
      drive(1'b0, w[15-i], 1'b1);
      if (m_valid) begin vcnt++; vpos = i; end
      if (i < 15 && m_busy !== 1'b1) busy_ok = 0;
    end
    total++;
    if (!busy_ok) begin bad++; $display("FAIL stall_busy: busy dropped mid-frame required 1"); end
    total++;
    if (vcnt !== 1 || vpos !== 15)
      begin bad++; $display("FAIL stall_latency: strobes=%0d at bit %0d required 1 at bit 15", vcnt, vpos); end
    total++;
    if (m_data !== 16'hA5A5 || m_ones !== 5'd8)
      begin bad++; $display("FAIL stall_data: data=%h ones=%0d required a5a5 8", m_data, m_ones); end
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    logic [15:0] w2;
    int vcnt, vpos;
    w2 = 16'h00F0; vcnt = 0; vpos = -1;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0, 1'b1, 1'b1);
      if (m_valid) vcnt++;
    end
    drive(1'b1, w2[15], 1'b1);
    total++;
    if (m_err !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'hA5A5 || m_busy !== 1'b1)
      begin bad++; $display("FAIL abort_edge: err=%b valid=%b data=%h busy=%b required 1 0 a5a5 1", m_err, m_valid, m_data, m_busy); end
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, w2[15-i], 1'b1);
      if (m_valid) begin vcnt++; vpos = i; end
    end
    total++;
    if (vcnt !== 1 || vpos !== 15)
      begin bad++; $display("FAIL abort_strobes: strobes=%0d last at %0d required 1 at 15", vcnt, vpos); end
    total++;
    if (m_data !== 16'h00F0 || m_ones !== 5'd4 || m_err !== 1'b1)
      begin bad++; $display("FAIL abort_data: data=%h ones=%0d err=%b required 00f0 4 1", m_data, m_ones, m_err); end
    clear_err = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clear_err = 1'b0;
    total++;
    if (m_err !== 1'b0) begin bad++; $display("FAIL clear_err: err=%b required 0", m_err); end
  endtask

  task automatic test_abort_last();
    int vcnt, vpos;
    vcnt = 0; vpos = -1;
    for (int i = 0; i < 15; i++) drive(i == 0, 1'b0, 1'b1);
    clear_err = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    clear_err = 1'b0;
    total++;
    if (m_valid !== 1'b0 || m_err !== 1'b1 || m_busy !== 1'b1)
      begin bad++; $display("FAIL abort_last_bit: valid=%b err=%b busy=%b required 0 1 1", m_valid, m_err, m_busy); end
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (m_valid) begin vcnt++; vpos = i; end
    end
    total++;
    if (vcnt !== 1 || vpos !== 15 || m_data !== 16'h8000 || m_ones !== 5'd1)
      begin bad++; $display("FAIL abort_last_restart: strobes=%0d at %0d data=%h ones=%0d required 1 15 8000 1", vcnt, vpos, m_data, m_ones); end
    clear_err = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    clear_err = 1'b0;
  endtask

  task automatic test_lsb_and_reset();
    for (int i = 0; i < 16; i++) drive(i == 0, i == 0, 1'b1);
    total++;
    if (l_valid !== 1'b1 || l_data !== 16'h0001 || l_ones !== 5'd1)
      begin bad++; $display("FAIL lsb_first: valid=%b data=%h ones=%0d required 1 0001 1", l_valid, l_data, l_ones); end
    total++;
    if (m_data !== 16'h8000) begin bad++; $display("FAIL msb_same_bits: got %h required 8000", m_data); end
    for (int i = 0; i < 4; i++) drive(i == 0, 1'b1, 1'b1);
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    total++;
    if (m_data !== 16'h0 || l_data !== 16'h0 || m_valid !== 1'b0 || l_busy !== 1'b0 || m_busy !== 1'b0)
      begin bad++; $display("FAIL mid_reset: mdata=%h ldata=%h valid=%b busy=%b%b required 0 0 0 00", m_data, l_data, m_valid, m_busy, l_busy); end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom), 1'b1);
      total++;
      if (m_valid !== 1'b0 || l_valid !== 1'b0 || m_busy !== 1'b0)
        begin bad++; $display("FAIL post_reset_quiet: valid=%b%b busy=%b required 00 0", m_valid, l_valid, m_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_abort();
    test_abort_last();
    test_lsb_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
